// File: rtl/return_addr_stack.sv
// Return-address stack: circular buffer of link addresses with a top pointer,
// zero-latency top-of-stack read, and one-cycle overflow/underflow pulses.
module return_addr_stack #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 8,
    parameter int OVERFLOW_MODE = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [DATA_WIDTH-1:0]        top_data,
    output logic                         valid,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [PTR_W-1:0]      ptr_reg, ptr_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  overflow_reg, overflow_next;
    logic                  underflow_reg, underflow_next;
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_addr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic is_empty;
    logic is_full;

    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == CNT_DEPTH);

    always_comb begin
        ptr_next       = ptr_reg;
        count_next     = count_reg;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        wr_en          = 1'b0;
        wr_addr        = ptr_reg;

        if (flush) begin
            // Storage is left as-is; only the bookkeeping is discarded.
            ptr_next   = '0;
            count_next = '0;
        end else if (push && pop) begin
            if (is_empty) begin
                ptr_next       = ptr_reg + PTR_ONE;
                wr_addr        = ptr_reg + PTR_ONE;
                wr_en          = 1'b1;
                count_next     = CNT_ONE;
                underflow_next = 1'b1;
            end else begin
                // Return immediately followed by a call: replace the top in place.
                wr_addr = ptr_reg;
                wr_en   = 1'b1;
            end
        end else if (push) begin
            if (!is_full) begin
                ptr_next   = ptr_reg + PTR_ONE;
                wr_addr    = ptr_reg + PTR_ONE;
                wr_en      = 1'b1;
                count_next = count_reg + CNT_ONE;
            end else begin
                overflow_next = 1'b1;
                if (OVERFLOW_MODE == 0) begin
                    // When full, the slot after the top holds the oldest entry.
                    ptr_next = ptr_reg + PTR_ONE;
                    wr_addr  = ptr_reg + PTR_ONE;
                    wr_en    = 1'b1;
                end
            end
        end else if (pop) begin
            if (is_empty) begin
                underflow_next = 1'b1;
            end else begin
                ptr_next   = ptr_reg - PTR_ONE;
                count_next = count_reg - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg       <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            ptr_reg       <= ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // One register per entry so reset can clear the whole array at once.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] entry_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    entry_reg <= '0;
                end else if (wr_en && (wr_addr == PTR_W'(gi))) begin
                    entry_reg <= push_data;
                end
            end

            assign mem[gi] = entry_reg;
        end
    endgenerate

    assign top_data  = is_empty ? '0 : mem[ptr_reg];
    assign valid     = !is_empty;
    assign full      = is_full;
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack: a wrap-mode and a reject-mode instance share
// stimulus and are compared against an array-shift stack model.
module tb_return_addr_stack;

    localparam int DW  = 32;
    localparam int DEP = 4;

    logic          clk;
    logic          reset;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic          flush;

    logic [DW-1:0] top_w, top_r;
    logic          valid_w, valid_r, full_w, full_r;
    logic [2:0]    count_w, count_r;
    logic          ovf_w, ovf_r, unf_w, unf_r;

    int checks = 0;
    int errors = 0;

    // Model: stk[m][0] is the oldest entry, stk[m][n[m]-1] the top.
    logic [31:0] stk [2][DEP];
    int          n [2];
    logic        ovf_e [2];
    logic        unf_e [2];

    return_addr_stack #(.DATA_WIDTH(DW), .DEPTH(DEP), .OVERFLOW_MODE(0)) dut_wrap (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data), .pop(pop),
        .flush(flush), .top_data(top_w), .valid(valid_w), .full(full_w),
        .count(count_w), .overflow(ovf_w), .underflow(unf_w)
    );

    return_addr_stack #(.DATA_WIDTH(DW), .DEPTH(DEP), .OVERFLOW_MODE(1)) dut_rej (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data), .pop(pop),
        .flush(flush), .top_data(top_r), .valid(valid_r), .full(full_r),
        .count(count_r), .overflow(ovf_r), .underflow(unf_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_top(input int m);
        if (n[m] == 0) return 32'h0;
        return stk[m][n[m]-1];
    endfunction

    function automatic void model_clear();
        for (int m = 0; m < 2; m++) begin
            n[m]     = 0;
            ovf_e[m] = 1'b0;
            unf_e[m] = 1'b0;
        end
    endfunction

    function automatic void model_step(input int m, input logic pu, input logic [31:0] d,
                                       input logic po, input logic fl);
        ovf_e[m] = 1'b0;
        unf_e[m] = 1'b0;
        if (fl) begin
            n[m] = 0;
        end else if (pu && po) begin
            if (n[m] == 0) begin
                stk[m][0] = d;
                n[m]      = 1;
                unf_e[m]  = 1'b1;
            end else begin
                stk[m][n[m]-1] = d;
            end
        end else if (pu) begin
            if (n[m] < DEP) begin
                stk[m][n[m]] = d;
                n[m]         = n[m] + 1;
            end else begin
                ovf_e[m] = 1'b1;
                if (m == 0) begin
                    for (int i = 0; i < DEP-1; i++) stk[m][i] = stk[m][i+1];
                    stk[m][DEP-1] = d;
                end
            end
        end else if (po) begin
            if (n[m] == 0) unf_e[m] = 1'b1;
            else           n[m] = n[m] - 1;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/w_count"}, 32'(count_w), 32'(n[0]));
        chk({tag, "/w_valid"}, 32'(valid_w), 32'(n[0] != 0));
        chk({tag, "/w_full"},  32'(full_w),  32'(n[0] == DEP));
        chk({tag, "/w_top"},   top_w,        exp_top(0));
        chk({tag, "/w_ovf"},   32'(ovf_w),   32'(ovf_e[0]));
        chk({tag, "/w_unf"},   32'(unf_w),   32'(unf_e[0]));
        chk({tag, "/r_count"}, 32'(count_r), 32'(n[1]));
        chk({tag, "/r_valid"}, 32'(valid_r), 32'(n[1] != 0));
        chk({tag, "/r_full"},  32'(full_r),  32'(n[1] == DEP));
        chk({tag, "/r_top"},   top_r,        exp_top(1));
        chk({tag, "/r_ovf"},   32'(ovf_r),   32'(ovf_e[1]));
        chk({tag, "/r_unf"},   32'(unf_r),   32'(unf_e[1]));
        $display("step %s: wrap cnt=%0d top=%0h | rej cnt=%0d top=%0h",
                 tag, count_w, top_w, count_r, top_r);
    endtask

    task automatic step(input logic pu, input logic [31:0] d, input logic po,
                        input logic fl, input string tag);
        push      = pu;
        push_data = d;
        pop       = po;
        flush     = fl;
        // Consumer reads the top in the same cycle it pops.
        chk({tag, "/w_pre_top"}, top_w, exp_top(0));
        chk({tag, "/r_pre_top"}, top_r, exp_top(1));
        @(posedge clk);
        model_step(0, pu, d, po, fl);
        model_step(1, pu, d, po, fl);
        #1;
        push      = 1'b0;
        push_data = '0;
        pop       = 1'b0;
        flush     = 1'b0;
        check_all(tag);
    endtask

    initial begin
        reset     = 1'b1;
        push      = 1'b0;
        push_data = '0;
        pop       = 1'b0;
        flush     = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset");

        // LIFO order
        step(1, 32'h10, 0, 0, "lifo_push10");
        step(1, 32'h20, 0, 0, "lifo_push20");
        step(1, 32'h30, 0, 0, "lifo_push30");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, "lifo_pop");

        // Five pushes into a four-deep stack, then drain
        for (int i = 1; i <= 5; i++) step(1, 32'(i * 16), 0, 0, "ovf_push");
        step(0, 0, 0, 0, "ovf_idle");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, "ovf_pop");

        // Underflow and replace-top
        step(0, 0, 1, 0, "unf_pop_empty");
        step(1, 32'hA0, 0, 0, "rep_pushA0");
        step(1, 32'hB0, 1, 0, "rep_pushpopB0");
        step(1, 32'hD0, 1, 1, "pushpop_after");
        step(1, 32'hE0, 1, 0, "pushpop_empty");

        // Flush priority over push and pop
        step(1, 32'h11, 0, 0, "fl_push");
        step(1, 32'h22, 1, 1, "fl_all");
        step(1, 32'hC0, 0, 0, "fl_pushC0");

        // Asynchronous reset in the middle of a cycle with three entries live
        step(1, 32'h33, 0, 0, "ar_push");
        step(1, 32'h44, 0, 0, "ar_push");
        #4;
        reset = 1'b1;
        model_clear();
        #1;
        chk("async_reset/w_count", 32'(count_w), 32'd0);
        chk("async_reset/w_valid", 32'(valid_w), 32'd0);
        chk("async_reset/w_top",   top_w,        32'd0);
        chk("async_reset/r_count", 32'(count_r), 32'd0);
        chk("async_reset/r_valid", 32'(valid_r), 32'd0);
        chk("async_reset/r_top",   top_r,        32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("async_reset_release");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic pu, po, fl;
            fl = ($urandom_range(0, 99) < 5);
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            step(pu, $urandom, po, fl, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Parametrised hardware return-address stack (RAS) for subroutine call/return in the pipelined core.
- Replaces the fixed stack behaviour inside the register file. Decode pushes the link address on JAL and pops the target on JS.
- Circular buffer with configurable depth, data width and overflow policy. Also provides occupancy, full/empty status and error pulses.
- Sits in the ID stage beside the jump unit. Its top-of-stack output feeds the JS target path.

Parameters:
- DATA_WIDTH, 32, width of each stored return address.
- DEPTH, 8, number of entries; power of two, >= 2.
- OVERFLOW_MODE, 0, 0 = wrap (overwrite oldest entry), 1 = reject (push ignored when full).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  push push_data this cycle.
- push_data  in  DATA_WIDTH  return address to store (PC+4 of JAL).
- pop  in  1  pop top entry this cycle.
- flush  in  1  discard all entries (pipeline redirect / context reset).
- top_data  out  DATA_WIDTH  current top entry; 0 when empty.
- valid  out  1  count != 0.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH+1)  number of live entries.
- overflow  out  1  registered one-cycle pulse: push attempted while full without a pop.
- underflow  out  1  registered one-cycle pulse: pop attempted while empty.

Behaviour:
- Reset (async, active-high), effective immediately mid-operation:
  - top pointer = 0, count = 0, overflow = 0, underflow = 0.
  - All storage entries cleared to 0.
  - Outputs: top_data = 0, valid = 0, full = 0.
- Storage: DEPTH x DATA_WIDTH registers, top pointer of $clog2(DEPTH) bits, count register. Pointer arithmetic is modulo DEPTH (natural wrap).
- Output timing:
  - top_data, valid, full and count are combinational from current state: zero read latency.
  - The consumer samples top_data in the same cycle it asserts pop.
  - A pushed value becomes visible on top_data the cycle after the push edge.
- Priority per rising edge: flush > (push & pop) > push > pop.
- flush: count = 0, pointer = 0, storage untouched, no error pulses. Concurrent push/pop are ignored.
- push only, not full: pointer += 1, mem[pointer+1] = push_data, count += 1.
- push only, full, OVERFLOW_MODE = 0:
  - pointer += 1 and the oldest entry is overwritten with push_data.
  - count stays DEPTH; overflow = 1 next cycle.
- push only, full, OVERFLOW_MODE = 1: no state change, overflow = 1 next cycle.
- pop only, count > 0: pointer -= 1, count -= 1; the entry is left stale.
- pop only, empty: no state change, underflow = 1 next cycle.
- push & pop, count > 0: mem[pointer] = push_data (replace top), pointer and count unchanged. No overflow even when full.
- push & pop, empty: treated as push; count = 1, underflow = 1 next cycle.
- overflow and underflow are high for exactly one cycle per offending edge and are cleared at every edge where no error occurs.
- Pointer and count after wrap:
  - Pointer wraps DEPTH-1 -> 0 on push and 0 -> DEPTH-1 on pop.
  - count never exceeds DEPTH and never goes below 0.
- Empty stack: top_data is forced to 0 regardless of stale storage.

Test Plan (DEPTH=4, DATA_WIDTH=32):
- Reset check: assert reset mid-clock with 3 entries live -> count=0, valid=0 and top_data=0 immediately, without waiting for a clock edge.
- LIFO order:
  - Stimulus: push 0x10, 0x20, 0x30 on consecutive cycles, then pop three times.
  - Response: top_data reads 0x30, 0x20, 0x10 in the pop cycles; count 3->0; valid falls after the third pop.
- Wrap overflow (MODE=0):
  - Stimulus: push 0x10..0x50 (five pushes).
  - Response: full=1, count=4, overflow pulses one cycle after the 5th push, top_data=0x50.
  - Then pop x4 -> reads 0x50, 0x40, 0x30, 0x20; 0x10 is lost.
- Reject overflow (MODE=1): same five pushes -> overflow pulse, top_data=0x40, count=4. Pops return 0x40..0x10.
- Underflow and replace:
  - pop on an empty stack -> underflow pulse, count stays 0, top_data=0.
  - push 0xA0, then push 0xB0 with pop in the same cycle -> count=1, top_data=0xB0, no overflow.
- Flush priority:
  - Stimulus: with 2 entries live, assert flush+push+pop in the same cycle.
  - Response: next cycle count=0, valid=0, top_data=0, no error pulses.
  - Following push 0xC0 -> top_data=0xC0, count=1.
